// File: rtl/traffic_ctrl_param.sv
// Parametrised intersection controller: main/side street lights plus a latched
// pedestrian walk phase, all phases timed in ticks from an internal prescaler.
module traffic_ctrl_param #(
    parameter int TICK_DIV         = 100_000_000,
    parameter int CNT_W            = 8,
    parameter int T_MAIN_G         = 6,
    parameter int T_MAIN_EXT       = 6,
    parameter int T_MAIN_EXT_SHORT = 3,
    parameter int T_YELLOW         = 2,
    parameter int T_PED            = 3,
    parameter int T_SIDE_G         = 6,
    parameter int T_SIDE_EXT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       side_sensor,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic       ped_light,
    output logic       ped_pending,
    output logic [2:0] state
);

    function automatic bit dur_ok(input int t);
        return (t >= 1) && (longint'(t) <= (longint'(1) << CNT_W));
    endfunction

    localparam bit PARAMS_OK = (TICK_DIV >= 1) && (CNT_W >= 1) &&
                               dur_ok(T_MAIN_G) && dur_ok(T_MAIN_EXT) &&
                               dur_ok(T_MAIN_EXT_SHORT) && dur_ok(T_YELLOW) &&
                               dur_ok(T_PED) && dur_ok(T_SIDE_G) && dur_ok(T_SIDE_EXT);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("traffic_ctrl_param: illegal TICK_DIV, CNT_W or phase duration");
        end
    endgenerate

    localparam int              PC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

    // Timer reload values: a phase of N ticks counts N-1 down to 0.
    localparam logic [CNT_W-1:0] LD_MAIN_G    = CNT_W'(T_MAIN_G - 1);
    localparam logic [CNT_W-1:0] LD_MAIN_EXT  = CNT_W'(T_MAIN_EXT - 1);
    localparam logic [CNT_W-1:0] LD_MAIN_EXTS = CNT_W'(T_MAIN_EXT_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_PED       = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] LD_SIDE_G    = CNT_W'(T_SIDE_G - 1);
    localparam logic [CNT_W-1:0] LD_SIDE_EXT  = CNT_W'(T_SIDE_EXT - 1);

    typedef enum logic [2:0] {
        S_MAIN_G   = 3'd0,
        S_MAIN_EXT = 3'd1,
        S_MAIN_Y   = 3'd2,
        S_PED_WALK = 3'd3,
        S_SIDE_G   = 3'd4,
        S_SIDE_EXT = 3'd5,
        S_SIDE_Y   = 3'd6,
        S_ILLEGAL  = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic             r_ped_pending;
    logic             w_ped_pending_next;
    logic             w_tick;
    logic             w_ped_enter;

    assign w_tick    = (r_pc == PC_LAST);
    assign w_pc_next = w_tick ? '0 : r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_MAIN_G;
            r_timer       <= LD_MAIN_G;
            r_pc          <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_pc          <= w_pc_next;
            r_ped_pending <= w_ped_pending_next;
        end
    end

    // Next state and timer; side_sensor and ped_pending matter only on terminal ticks.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        if (r_state == S_ILLEGAL) begin
            w_state_next = S_MAIN_G;
            w_timer_next = LD_MAIN_G;
        end else if (w_tick) begin
            if (r_timer == '0) begin
                case (r_state)
                    S_MAIN_G: begin
                        w_state_next = S_MAIN_EXT;
                        w_timer_next = side_sensor ? LD_MAIN_EXTS : LD_MAIN_EXT;
                    end
                    S_MAIN_EXT: begin
                        w_state_next = S_MAIN_Y;
                        w_timer_next = LD_YELLOW;
                    end
                    S_MAIN_Y: begin
                        if (r_ped_pending) begin
                            w_state_next = S_PED_WALK;
                            w_timer_next = LD_PED;
                        end else begin
                            w_state_next = S_SIDE_G;
                            w_timer_next = LD_SIDE_G;
                        end
                    end
                    S_PED_WALK: begin
                        w_state_next = S_SIDE_G;
                        w_timer_next = LD_SIDE_G;
                    end
                    S_SIDE_G: begin
                        if (side_sensor) begin
                            w_state_next = S_SIDE_EXT;
                            w_timer_next = LD_SIDE_EXT;
                        end else begin
                            w_state_next = S_SIDE_Y;
                            w_timer_next = LD_YELLOW;
                        end
                    end
                    S_SIDE_EXT: begin
                        w_state_next = S_SIDE_Y;
                        w_timer_next = LD_YELLOW;
                    end
                    default: begin
                        w_state_next = S_MAIN_G;
                        w_timer_next = LD_MAIN_G;
                    end
                endcase
            end else begin
                w_timer_next = r_timer - 1'b1;
            end
        end
    end

    // Clearing on walk entry beats a press in the same cycle; presses during the walk are dropped.
    assign w_ped_enter = (w_state_next == S_PED_WALK) && (r_state != S_PED_WALK);

    always_comb begin
        w_ped_pending_next = r_ped_pending | ped_btn;
        if (w_ped_enter) begin
            w_ped_pending_next = 1'b0;
        end else if (r_state == S_PED_WALK) begin
            w_ped_pending_next = r_ped_pending;
        end
    end

    always_comb begin
        main_r    = 1'b0;
        main_y    = 1'b0;
        main_g    = 1'b0;
        side_r    = 1'b0;
        side_y    = 1'b0;
        side_g    = 1'b0;
        ped_light = 1'b0;
        case (r_state)
            S_MAIN_G, S_MAIN_EXT: begin
                main_g = 1'b1;
                side_r = 1'b1;
            end
            S_MAIN_Y: begin
                main_y = 1'b1;
                side_r = 1'b1;
            end
            S_PED_WALK: begin
                main_r    = 1'b1;
                side_r    = 1'b1;
                ped_light = 1'b1;
            end
            S_SIDE_G, S_SIDE_EXT: begin
                main_r = 1'b1;
                side_g = 1'b1;
            end
            S_SIDE_Y: begin
                main_r = 1'b1;
                side_y = 1'b1;
            end
            default: begin
                main_r = 1'b1;
                side_r = 1'b1;
            end
        endcase
    end

    assign ped_pending = r_ped_pending;
    assign state       = r_state;

endmodule

// File: doc/traffic_ctrl_param.md
# traffic_ctrl_param

Parametrised successor to the fixed-timing traffic controller, used as the intersection controller in the Lab2 top level. It drives main-street and side-street red/yellow/green lights and a pedestrian walk light. All phase durations and the tick rate are parameters. The block has an internal tick generator, latches pedestrian requests until they are served, and has a synchronous reset. Lights are decoded from the state register; the block has no dependence on a divided clock.

## Interface
- TICK_DIV, 100_000_000: clk cycles per timing tick; minimum 1.
- CNT_W, 8: phase timer width; every T_* must be ≤ 2^CNT_W.
- T_MAIN_G, 6: ticks in MAIN_G.
- T_MAIN_EXT, 6: ticks in MAIN_EXT when side_sensor = 0 on entry.
- T_MAIN_EXT_SHORT, 3: ticks in MAIN_EXT when side_sensor = 1 on entry.
- T_YELLOW, 2: ticks in MAIN_Y and in SIDE_Y.
- T_PED, 3: ticks in PED_WALK.
- T_SIDE_G, 6: ticks in SIDE_G.
- T_SIDE_EXT, 3: ticks in SIDE_EXT.

Ports:
- clk, in, 1: system clock. One clock domain; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- ped_btn, in, 1: pedestrian button, already synchronised; any 1-cycle high is a request.
- side_sensor, in, 1: side-street traffic sensor, already synchronised, level.
- main_r / main_y / main_g, out, 1 each: main-street lights.
- side_r / side_y / side_g, out, 1 each: side-street lights.
- ped_light, out, 1: walk light.
- ped_pending, out, 1: a latched pedestrian request is waiting.
- state, out, 3: current state code (debug).

## Operation
- **Tick generator.** Prescale counter `pc` counts 0..TICK_DIV-1 and wraps. `tick` = (pc == TICK_DIV-1). With TICK_DIV = 1, `tick` is 1 every cycle.
- **Phase timer.** On entering any state, the timer loads (duration-1). It decrements on each tick. A transition occurs on the tick where timer == 0. Each state therefore lasts exactly its duration in ticks.
- **States, codes and transitions:**
  - MAIN_G (0) -> MAIN_EXT.
  - MAIN_EXT (1) -> MAIN_Y. Its duration is T_MAIN_EXT_SHORT if side_sensor = 1 on the transition cycle into it, else T_MAIN_EXT.
  - MAIN_Y (2) -> PED_WALK if ped_pending = 1 on the transition cycle, else SIDE_G.
  - PED_WALK (3) -> SIDE_G.
  - SIDE_G (4) -> SIDE_EXT if side_sensor = 1 on the transition cycle, else SIDE_Y.
  - SIDE_EXT (5) -> SIDE_Y.
  - SIDE_Y (6) -> MAIN_G.
  - Code 7 is illegal; it goes to MAIN_G on the next cycle with the timer reloaded.
- **Light decode** (pure function of the state register):
  - MAIN_G, MAIN_EXT: main_g, side_r.
  - MAIN_Y: main_y, side_r.
  - PED_WALK: main_r, side_r, ped_light.
  - SIDE_G, SIDE_EXT: main_r, side_g.
  - SIDE_Y: main_r, side_y.
  - Exactly one light per street is on at all times.
- **Pedestrian latch:**
  - Set on any cycle with ped_btn = 1.
  - Cleared on the clock edge that enters PED_WALK.
  - Presses while in PED_WALK, or on the entry cycle itself, are ignored; clear wins.
  - A press in any other state, including SIDE_*, is held for the next MAIN_Y exit.
- **Sensor sampling.** side_sensor is sampled only on transition cycles; its level at any other time has no effect.

## Timing
- **Reset values** (the cycle after rst is high at a clock edge):
  - state = MAIN_G (0).
  - main_g = 1, side_r = 1; all other lights = 0.
  - ped_pending = 0, pc = 0, timer = T_MAIN_G-1.
- rst has priority over every other input, including a tick in the same cycle.
- Reset mid-phase abandons the phase; the next MAIN_G lasts a full T_MAIN_G ticks, measured from reset release.
- The first tick after reset release occurs TICK_DIV cycles after release (pc counts from 0).
- **Latencies:**
  - State and lights change on the clock edge of the terminal tick, with no extra cycle.
  - ped_pending rises 1 cycle after the first ped_btn-high edge.
- **Cycle lengths:**
  - No sensor, no pedestrian: 22 ticks (6+6+2+6+2).
  - Sensor held high: 6+3+2+6+3+2 = 22 ticks.
  - A pedestrian phase adds T_PED.
- **Timer arithmetic.** The timer is unsigned CNT_W bits and never wraps: it is reloaded before it can pass 0. Parameter violations are flagged by a simulation-time elaboration check.

## Test plan
1. TICK_DIV=4, defaults, rst for 2 cycles, ped_btn=0, side_sensor=0.
   -> state sequence 0,1,2,4,6,0 held for 24,24,8,24,8 clk.
   -> main_g=1/side_r=1 directly after reset.
2. TICK_DIV=4, side_sensor=1 held.
   -> MAIN_EXT lasts 12 clk; SIDE_EXT (5) is inserted for 12 clk.
   -> state 4->5->6; full cycle 88 clk.
3. One-cycle ped_btn pulse during MAIN_G.
   -> ped_pending=1 on the next cycle.
   -> after MAIN_Y, state 3 for 12 clk with main_r=side_r=ped_light=1.
   -> ped_pending=0 from PED_WALK entry; the following cycle has no PED_WALK.
4. ped_btn held high across the whole PED_WALK, released before SIDE_G.
   -> ped_pending stays 0; no second walk phase.
   Separately, ped_btn pulsed during SIDE_Y -> walk occurs after the next MAIN_Y.
5. rst asserted for 1 cycle mid-SIDE_G with ped_pending=1 and a tick in the same cycle.
   -> next cycle: state=0, main_g=1, side_r=1, ped_pending=0.
   -> MAIN_G lasts 24 clk from release.
6. TICK_DIV=1, T_YELLOW=1, T_PED=1.
   -> each yellow and walk state lasts exactly 1 clk.
   -> lights are never both green; exactly one light per street every cycle.
